// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension multiply/divide unit:
// funct3 operation encodings, FSM states and special-case result constants.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Divide-class ops occupy the upper half of the funct3 space.
  function automatic logic is_div_op(input muldiv_op_e op);
    logic [2:0] raw;
    raw = op;
    return raw[2];
  endfunction

  // REM/REMU differ from DIV/DIVU in bit 1.
  function automatic logic is_rem_op(input muldiv_op_e op);
    logic [2:0] raw;
    raw = op;
    return raw[2] & raw[1];
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: per-op signedness, operand signs,
// magnitudes, and the divide-by-zero / signed-overflow special-case flags.
module muldiv_operand_prep
  import rv32_pkg::*;
(
  input  muldiv_op_e       op_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  output logic             sign_a_o,
  output logic             sign_b_o,
  output logic [XLEN-1:0]  mag_a_o,
  output logic [XLEN-1:0]  mag_b_o,
  output logic             div0_o,
  output logic             ovf_o
);

  logic signed_a;
  logic signed_b;

  assign signed_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                    (op_i == OP_DIV)  || (op_i == OP_REM);
  assign signed_b = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);

  assign sign_a_o = signed_a & op_a_i[XLEN-1];
  assign sign_b_o = signed_b & op_b_i[XLEN-1];

  // INT_MIN maps to 0x80000000, which is still the correct unsigned magnitude.
  assign mag_a_o = sign_a_o ? (~op_a_i + 1'b1) : op_a_i;
  assign mag_b_o = sign_b_o ? (~op_b_i + 1'b1) : op_b_i;

  assign div0_o = is_div_op(op_i) && (op_b_i == '0);
  assign ovf_o  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                  (op_a_i == INT_MIN) && (op_b_i == '1);

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Optional macro FAST_MUL_EN: multiplies complete in one cycle via a wide multiplier.
module ex_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_e,
  input  logic [2:0]       funct3_e,
  input  logic [XLEN-1:0]  op_a_e,
  input  logic [XLEN-1:0]  op_b_e,
  input  logic             kill,
  output logic             stall,
  output logic             result_valid,
  output logic [XLEN-1:0]  result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  muldiv_state_e    state_q;
  muldiv_op_e       op_q;
  logic             sa_q, sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  acc_hi_q, acc_lo_q, opnd_q;
  logic [XLEN-1:0]  result_q;
  logic             result_valid_q;

  muldiv_op_e      op_in;
  logic            sign_a, sign_b, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_in = muldiv_op_e'(funct3_e);

  muldiv_operand_prep u_prep (
    .op_i     (op_in),
    .op_a_i   (op_a_e),
    .op_b_i   (op_b_e),
    .sign_a_o (sign_a),
    .sign_b_o (sign_b),
    .mag_a_o  (mag_a),
    .mag_b_o  (mag_b),
    .div0_o   (div0),
    .ovf_o    (ovf)
  );

  // One engine step. Multiply keeps {acc_hi, acc_lo} as partial product over
  // the shifting multiplier; divide keeps remainder in acc_hi, dividend/quotient in acc_lo.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_hi_d, acc_lo_d;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];
    if (is_div_op(op_q)) begin
      acc_hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_hi_d = mul_sum[XLEN:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_mag, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, calc_res;

  always_comb begin
    prod_mag = {acc_hi_d, acc_lo_d};
    prod_s   = (sa_q ^ sb_q) ? (~prod_mag + 1'b1) : prod_mag;
    quot_s   = (sa_q ^ sb_q) ? (~acc_lo_d + 1'b1) : acc_lo_d;
    rem_s    = sa_q ? (~acc_hi_d + 1'b1) : acc_hi_d;
    calc_res = '0;
    case (op_q)
      OP_MUL:                        calc_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_res = quot_s;
      OP_REM, OP_REMU:               calc_res = rem_s;
      default:                       calc_res = '0;
    endcase
  end

  logic            special;
  logic [XLEN-1:0] spec_res;
`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = $signed({{XLEN{sign_a}}, op_a_e}) * $signed({{XLEN{sign_b}}, op_b_e});
`endif

  always_comb begin
    special  = div0 | ovf;
    spec_res = '0;
    if (div0) begin
      spec_res = is_rem_op(op_in) ? op_a_e : DIV0_QUOT;
    end else if (ovf) begin
      spec_res = is_rem_op(op_in) ? '0 : INT_MIN;
    end
`ifdef FAST_MUL_EN
    if (!is_div_op(op_in)) begin
      special  = 1'b1;
      spec_res = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= OP_MUL;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      cnt_q          <= '0;
      acc_hi_q       <= '0;
      acc_lo_q       <= '0;
      opnd_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (kill) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (valid_e) begin
            op_q  <= op_in;
            sa_q  <= sign_a;
            sb_q  <= sign_b;
            cnt_q <= '0;
            if (special) begin
              result_q       <= spec_res;
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end else begin
              acc_hi_q <= '0;
              acc_lo_q <= is_div_op(op_in) ? mag_a : mag_b;
              opnd_q   <= is_div_op(op_in) ? mag_b : mag_a;
              state_q  <= CALC;
            end
          end
          CALC: begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              result_q       <= calc_res;
              result_valid_q <= 1'b1;
              state_q        <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign stall        = ~kill & (((state_q == IDLE) & valid_e) | (state_q == CALC));
  assign result_valid = result_valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random ops against an
// arithmetic reference model, plus kill, reset and back-to-back scenarios.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_e;
  logic [2:0]  funct3_e;
  logic [31:0] op_a_e, op_b_e;
  logic        kill;
  logic        stall, result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_e      (valid_e),
    .funct3_e     (funct3_e),
    .op_a_e       (op_a_e),
    .op_b_e       (op_b_e),
    .kill         (kill),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  // Issues one op from IDLE and checks result, latency, stall window and single pulse.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int lat, k, stall_cnt;
    exp = ref_res(f3, a, b);
    lat = ref_lat(f3, a, b);
    valid_e = 1'b1; funct3_e = f3; op_a_e = a; op_b_e = b;
    #1;
    chk({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
    step();
    valid_e = 1'b0; op_a_e = $urandom; op_b_e = $urandom; funct3_e = 3'($urandom);
    k = 1; stall_cnt = 0;
    while (!result_valid && k < 60) begin
      if (stall) stall_cnt++;
      step();
      k++;
    end
    $display("op %s f3=%0d a=%h b=%h -> result=%h lat=%0d (exp %h lat %0d)", tag, f3, a, b, result, k, exp, lat);
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat - 1));
    chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    step();
    chk({tag, "_single_pulse"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int pulses, first_k, second_k;
    logic [31:0] first_res, second_res;
    logic [2:0] rf3;
    logic [31:0] ra, rb;

    rst_n = 1'b0; valid_e = 1'b0; kill = 1'b0; funct3_e = 3'd0; op_a_e = '0; op_b_e = '0;
    step(); step(); step();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    step();

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mul");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         "div");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         "rem");
    run_op(3'd5, 32'd100,        32'd7,         "divu");
    run_op(3'd7, 32'd100,        32'd7,         "remu");
    run_op(3'd4, 32'd5,          32'd0,         "div0");
    run_op(3'd6, 32'd5,          32'd0,         "rem0");
    run_op(3'd5, 32'd5,          32'd0,         "divu0");
    run_op(3'd7, 32'd5,          32'd0,         "remu0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");

    for (int i = 0; i < 30; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rf3, ra, rb, "rand");
    end

    // kill at N+10 of a divide
    valid_e = 1'b1; funct3_e = 3'd5; op_a_e = 32'd1000; op_b_e = 32'd3;
    step();
    valid_e = 1'b0;
    repeat (9) step();
    kill = 1'b1;
    #1;
    chk("kill_stall_low", {31'd0, stall}, 32'd0);
    step();
    kill = 1'b0;
    chk("kill_idle_stall", {31'd0, stall}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid) pulses++;
      step();
    end
    $display("kill mid-op: result_valid pulses after kill=%0d", pulses);
    chk("kill_no_result", 32'(pulses), 32'd0);

    // kill together with a start in IDLE
    valid_e = 1'b1; funct3_e = 3'd0; op_a_e = 32'd3; op_b_e = 32'd4; kill = 1'b1;
    #1;
    chk("kill_idle_start_stall", {31'd0, stall}, 32'd0);
    step();
    valid_e = 1'b0; kill = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid || stall) pulses++;
      step();
    end
    $display("kill at start: busy/valid cycles=%0d", pulses);
    chk("kill_idle_no_start", 32'(pulses), 32'd0);

    // synchronous reset mid-op at N+5
    run_op(3'd7, 32'd100, 32'd7, "pre_reset");
    valid_e = 1'b1; funct3_e = 3'd0; op_a_e = 32'd7; op_b_e = 32'd3;
    step();
    valid_e = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    $display("reset mid-op: stall=%0b result_valid=%0b result=%h", stall, result_valid, result);
    chk("midreset_stall", {31'd0, stall}, 32'd0);
    chk("midreset_valid", {31'd0, result_valid}, 32'd0);
    chk("midreset_result", result, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid) pulses++;
      step();
    end
    chk("midreset_discard", 32'(pulses), 32'd0);

    // back-to-back DIVU with valid_e held; operands change during the first CALC
    valid_e = 1'b1; funct3_e = 3'd5; op_a_e = 32'd100; op_b_e = 32'd7;
    pulses = 0; first_k = -1; second_k = -1; first_res = '0; second_res = '0;
    for (int k = 0; k <= 90; k++) begin
      if (k == 1) begin op_a_e = 32'd1000; op_b_e = 32'd9; end
      if (k == 33) chk("b2b_stall_done", {31'd0, stall}, 32'd0);
      if (k == 34) chk("b2b_stall_restart", {31'd0, stall}, 32'd1);
      if (k == 35) valid_e = 1'b0;
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin first_k = k; first_res = result; end
        if (pulses == 2) begin second_k = k; second_res = result; end
      end
      step();
    end
    $display("back-to-back: pulses=%0d at %0d (%h) and %0d (%h)", pulses, first_k, first_res, second_k, second_res);
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_first_cycle", 32'(first_k), 32'd33);
    chk("b2b_first_result", first_res, 32'd14);
    chk("b2b_gap", 32'(second_k - first_k), 32'd34);
    chk("b2b_second_result", second_res, 32'd111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
